rtc_time_writer: RTL and testbench

- Commits user-edited BCD time (hours/minutes/seconds, AM/PM, 12/24 format) back into the external RTC over its multiplexed address/data bus.
- Sits downstream of the time-editing block: that block reads and edits time; this block writes the result back to the chip.
- On a commit pulse it latches the time and runs four fixed write transactions: seconds, minutes, hours, transfer command.
- Then it returns to idle and reports completion.

---
 rtl/rtc_time_writer.sv | 154 +++++++++++++++
 tb/tb_rtc_time_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_writer.sv
// Writes a latched BCD time back to the RTC as four multiplexed-bus write transactions.
// Optional start-time range checking with err pulse: define RTC_WR_CHECK_EN.
module rtc_time_writer #(
   parameter int         PHASE_CYC = 4,
   parameter logic [7:0] ADDR_SEC  = 8'h21,
   parameter logic [7:0] ADDR_MIN  = 8'h22,
   parameter logic [7:0] ADDR_HOUR = 8'h23,
   parameter logic [7:0] ADDR_XFER = 8'hF2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] hc,
   input  logic [7:0] mc,
   input  logic [7:0] sc,
   input  logic       ampm,
   input  logic       fmt,
   output logic       cs_n,
   output logic       ad_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);
   typedef enum logic [2:0] {IDLE, LOAD, A_SET, A_STB, D_SET, D_STB, GAP} state_t;

   localparam logic [7:0] PLOAD = 8'(PHASE_CYC - 1);

   state_t     state, state_d;
   logic [7:0] cnt, cnt_d;
   logic [1:0] idx, idx_d;
   logic [7:0] hc_r, mc_r, sc_r;
   logic       ampm_r, fmt_r;
   logic       accept, finish, reject;
   logic [7:0] addr, data, hour_byte;
   logic       unused_hc;

   assign unused_hc = &{1'b0, hc_r[7:6]};

`ifdef RTC_WR_CHECK_EN
   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   // Checked on the raw inputs so a rejected start never raises busy.
   assign reject = !(bcd_ok(sc, 8'h59) && bcd_ok(mc, 8'h59) &&
                     (fmt ? (bcd_ok(hc, 8'h12) && hc != 8'h00) : bcd_ok(hc, 8'h23)));

   always_ff @(posedge clk) begin
      if (reset) err <= 1'b0;
      else       err <= (state == IDLE) && start && reject;
   end
`else
   assign reject = 1'b0;
   assign err    = 1'b0;
`endif

   assign hour_byte = fmt_r ? {2'b10, ampm_r, hc_r[4:0]} : {2'b00, hc_r[5:0]};

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: if (start && !reject) begin
            state_d = LOAD;
            idx_d   = 2'd0;
            accept  = 1'b1;
         end
         LOAD: begin
            state_d = A_SET;
            cnt_d   = PLOAD;
         end
         default: begin
            if (cnt != 8'd0) cnt_d = cnt - 8'd1;
            else begin
               cnt_d = PLOAD;
               case (state)
                  A_SET:   state_d = A_STB;
                  A_STB:   state_d = D_SET;
                  D_SET:   state_d = D_STB;
                  D_STB:   state_d = GAP;
                  GAP: if (idx == 2'd3) begin
                     state_d = IDLE;
                     finish  = 1'b1;
                  end else begin
                     idx_d   = idx + 2'd1;
                     state_d = A_SET;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      addr = ADDR_XFER;
      data = 8'h00;
      case (idx_d)
         2'd0: begin addr = ADDR_SEC;  data = sc_r;      end
         2'd1: begin addr = ADDR_MIN;  data = mc_r;      end
         2'd2: begin addr = ADDR_HOUR; data = hour_byte; end
         default: ;
      endcase
   end

   // Bus outputs are registered from the next state so they switch cleanly with the phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         idx     <= 2'd0;
         hc_r    <= 8'h00;
         mc_r    <= 8'h00;
         sc_r    <= 8'h00;
         ampm_r  <= 1'b0;
         fmt_r   <= 1'b0;
         cs_n    <= 1'b1;
         ad_n    <= 1'b1;
         wr_n    <= 1'b1;
         rd_n    <= 1'b1;
         bus_out <= 8'h00;
         bus_oe  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
         if (accept) begin
            hc_r   <= hc;
            mc_r   <= mc;
            sc_r   <= sc;
            ampm_r <= ampm;
            fmt_r  <= fmt;
         end
         cs_n   <= !(state_d inside {A_SET, A_STB, D_SET, D_STB});
         bus_oe <=  (state_d inside {A_SET, A_STB, D_SET, D_STB});
         ad_n   <= !(state_d inside {A_SET, A_STB});
         wr_n   <= !(state_d inside {A_STB, D_STB});
         rd_n   <= 1'b1;
         if (state_d == A_SET && state != A_SET) bus_out <= addr;
         if (state_d == D_SET && state != D_SET) bus_out <= data;
         busy <= (state_d != IDLE);
         done <= finish;
      end
   end
endmodule

// File: tb/tb_rtc_time_writer.sv
// Randomized self-checking bench for rtc_time_writer against a transaction-level model.
module tb_rtc_time_writer;
   localparam int P   = 4;
   localparam int LAT = 20 * P + 1;

   logic       clk = 1'b0, reset = 1'b1, start = 1'b0, ampm = 1'b0, fmt = 1'b0;
   logic [7:0] hc = 8'h00, mc = 8'h00, sc = 8'h00;
   logic       cs_n, ad_n, wr_n, rd_n, bus_oe, busy, done, err;
   logic [7:0] bus_out;

   int errors = 0, checks = 0;

   logic [7:0] cap_addr[$], cap_data[$];
   int         cap_stb[$];
   int         cap_csfall, cap_lat, cap_done, cap_unstable, cap_rdbad, cap_oebad, cap_busylow, cap_err;

   rtc_time_writer #(.PHASE_CYC(P)) dut (
      .clk(clk), .reset(reset), .start(start), .hc(hc), .mc(mc), .sc(sc),
      .ampm(ampm), .fmt(fmt), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
      .bus_out(bus_out), .bus_oe(bus_oe), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   // Hours register: 12 h adds the mode flag (0x80) and PM flag (0x20) above the BCD hour.
   function automatic logic [7:0] ref_hour(input logic [7:0] h, input bit f, input bit pm);
      return f ? 8'(8'h80 + (pm ? 8'h20 : 8'h00) + h) : h;
   endfunction

   // Issues start from a negedge, then records bus activity until done plus 'tail' cycles.
   task automatic capture(input bit spam, input int tail);
      logic [7:0] first;
      int         run;
      logic       prev_cs, prev_wr;
      cap_addr.delete(); cap_data.delete(); cap_stb.delete();
      cap_csfall = 0; cap_lat = -1; cap_done = 0; cap_unstable = 0;
      cap_rdbad = 0; cap_oebad = 0; cap_busylow = 0; cap_err = 0;
      start = 1'b1;
      @(posedge clk); #1;
      if (!spam) start = 1'b0;
      prev_cs = 1'b1; prev_wr = 1'b1; run = 0; first = 8'h00;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         if (!cs_n && prev_cs) cap_csfall++;
         if (!wr_n) begin
            if (prev_wr) begin
               first = bus_out; run = 1;
               if (!ad_n) cap_addr.push_back(bus_out);
               else       cap_data.push_back(bus_out);
            end else begin
               run++;
               if (bus_out !== first) cap_unstable++;
            end
         end else if (!prev_wr) cap_stb.push_back(run);
         prev_cs = cs_n; prev_wr = wr_n;
         if (rd_n !== 1'b1) cap_rdbad++;
         if (bus_oe !== ~cs_n) cap_oebad++;
         if (err) cap_err++;
         if (done) begin
            cap_done++;
            if (cap_lat < 0) cap_lat = k;
         end else if (cap_lat < 0 && busy !== 1'b1) cap_busylow++;
         if (spam) begin
            if (k < 60) begin start = 1'b1; hc = to_bcd($urandom_range(0, 23)); end
            else start = 1'b0;
         end
         if (cap_lat >= 0 && k >= cap_lat + tail) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus_out !== 8'h00 || err !== 1'b0) begin
         errors++; $display("FAIL reset_bus: bus_out=%h err=%b want 00 0", bus_out, err);
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({cs_n, ad_n, wr_n, rd_n, bus_oe, busy, done, err} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: got %b want 11110000", i,
                     {cs_n, ad_n, wr_n, rd_n, bus_oe, busy, done, err});
         end
      end
   endtask

   task automatic test_sequences();
      logic [7:0] d_hc[3]   = '{8'h23, 8'h11, 8'h12};
      logic [7:0] d_mc[3]   = '{8'h45, 8'h30, 8'h00};
      logic [7:0] d_sc[3]   = '{8'h07, 8'h59, 8'h00};
      bit         d_pm[3]   = '{1'b0, 1'b1, 1'b0};
      bit         d_fmt[3]  = '{1'b0, 1'b1, 1'b1};
      logic [7:0] d_hour[3] = '{8'h23, 8'hB1, 8'h92};
      logic [7:0] ea[4] = '{8'h21, 8'h22, 8'h23, 8'hF2};
      logic [7:0] ed[4];
      for (int n = 0; n < 8; n++) begin
         if (n < 3) begin
            hc = d_hc[n]; mc = d_mc[n]; sc = d_sc[n]; ampm = d_pm[n]; fmt = d_fmt[n];
            ed[2] = d_hour[n];
         end else begin
            fmt  = 1'($urandom_range(0, 1));
            ampm = 1'($urandom_range(0, 1));
            hc   = fmt ? to_bcd($urandom_range(1, 12)) : to_bcd($urandom_range(0, 23));
            mc   = to_bcd($urandom_range(0, 59));
            sc   = to_bcd($urandom_range(0, 59));
            ed[2] = ref_hour(hc, fmt, ampm);
         end
         ed[0] = sc; ed[1] = mc; ed[3] = 8'h00;
         capture(1'b0, 3);
         checks++;
         if (cap_addr.size() != 4 || cap_data.size() != 4 || cap_stb.size() != 8) begin
            errors++;
            $display("FAIL seq%0d strobes: got addr=%0d data=%0d windows=%0d want 4 4 8",
                     n, cap_addr.size(), cap_data.size(), cap_stb.size());
         end else begin
            for (int i = 0; i < 4; i++) begin
               checks += 2;
               if (cap_addr[i] !== ea[i]) begin
                  errors++; $display("FAIL seq%0d addr%0d: got %h want %h", n, i, cap_addr[i], ea[i]);
               end
               if (cap_data[i] !== ed[i]) begin
                  errors++; $display("FAIL seq%0d data%0d: got %h want %h", n, i, cap_data[i], ed[i]);
               end
            end
            for (int i = 0; i < 8; i++) begin
               checks++;
               if (cap_stb[i] != P) begin
                  errors++; $display("FAIL seq%0d wr_len%0d: got %0d want %0d", n, i, cap_stb[i], P);
               end
            end
         end
         checks += 4;
         if (cap_lat != LAT) begin
            errors++; $display("FAIL seq%0d latency: got %0d want %0d", n, cap_lat, LAT);
         end
         if (cap_done != 1) begin
            errors++; $display("FAIL seq%0d done_count: got %0d want 1", n, cap_done);
         end
         if (cap_csfall != 4) begin
            errors++; $display("FAIL seq%0d cs_windows: got %0d want 4", n, cap_csfall);
         end
         if (cap_unstable + cap_rdbad + cap_oebad + cap_busylow + cap_err != 0) begin
            errors++;
            $display("FAIL seq%0d protocol: unstable=%0d rd=%0d oe=%0d busy=%0d err=%0d want all 0",
                     n, cap_unstable, cap_rdbad, cap_oebad, cap_busylow, cap_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_h;
      hc = 8'h08; mc = 8'h15; sc = 8'h33; fmt = 1'b0; ampm = 1'b0;
      exp_h = ref_hour(8'h08, 1'b0, 1'b0);
      capture(1'b1, 10);
      checks += 4;
      if (cap_data.size() != 4 || cap_data[2] !== exp_h) begin
         errors++; $display("FAIL spam_hour: got n=%0d h=%h want 4 %h", cap_data.size(),
                            cap_data.size() > 2 ? cap_data[2] : 8'hxx, exp_h);
      end
      if (cap_done != 1) begin
         errors++; $display("FAIL spam_done_count: got %0d want 1", cap_done);
      end
      if (cap_csfall != 4) begin
         errors++; $display("FAIL spam_cs_windows: got %0d want 4", cap_csfall);
      end
      if (cap_lat != LAT) begin
         errors++; $display("FAIL spam_latency: got %0d want %0d", cap_lat, LAT);
      end
      // Second start lands exactly in the done cycle of the first.
      hc = 8'h14; mc = 8'h00; sc = 8'h01;
      capture(1'b0, 0);
      hc = 8'h21; mc = 8'h02; sc = 8'h03; fmt = 1'b1; ampm = 1'b1;
      exp_h = ref_hour(8'h21 & 8'h1F, 1'b1, 1'b1);
      fmt = 1'b0; exp_h = ref_hour(8'h21, 1'b0, 1'b0);
      capture(1'b0, 3);
      checks += 2;
      if (cap_lat != LAT) begin
         errors++; $display("FAIL restart_latency: got %0d want %0d", cap_lat, LAT);
      end
      if (cap_data.size() != 4 || cap_data[2] !== exp_h || cap_data[0] !== 8'h03) begin
         errors++; $display("FAIL restart_data: got n=%0d want 4 with sec 03 hour %h", cap_data.size(), exp_h);
      end
   endtask

   task automatic test_reset_mid();
      int nd, ncs;
      hc = 8'h10; mc = 8'h42; sc = 8'h05; fmt = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (34) @(posedge clk);
      @(negedge clk);
      checks++;
      if (wr_n !== 1'b0 || ad_n !== 1'b1 || bus_out !== 8'h42) begin
         errors++; $display("FAIL mid_dstb: got wr_n=%b ad_n=%b bus=%h want 0 1 42", wr_n, ad_n, bus_out);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({wr_n, cs_n, bus_oe, busy, done} !== 5'b11000) begin
         errors++; $display("FAIL mid_reset: got %b want 11000", {wr_n, cs_n, bus_oe, busy, done});
      end
      @(negedge clk);
      reset = 1'b0;
      nd = 0; ncs = 0;
      repeat (100) begin
         @(negedge clk);
         if (done) nd++;
         if (!cs_n || busy) ncs++;
      end
      checks++;
      if (nd != 0 || ncs != 0) begin
         errors++; $display("FAIL mid_after: got done=%0d active=%0d want 0 0", nd, ncs);
      end
   endtask

   task automatic test_check();
      hc = 8'h13; mc = 8'h20; sc = 8'h10; fmt = 1'b1; ampm = 1'b0;
`ifdef RTC_WR_CHECK_EN
      begin
         int ne, na;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         checks++;
         if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL chk_err: got err=%b busy=%b want 1 0", err, busy);
         end
         ne = 0; na = 0;
         repeat (30) begin
            @(negedge clk);
            if (err) ne++;
            if (!cs_n || busy || done) na++;
         end
         checks++;
         if (ne != 0 || na != 0) begin
            errors++; $display("FAIL chk_quiet: got err=%0d active=%0d want 0 0", ne, na);
         end
      end
      hc = 8'h12;
      capture(1'b0, 3);
      checks++;
      if (cap_lat != LAT || cap_err != 0 || cap_data.size() != 4 || cap_data[2] !== 8'h92) begin
         errors++; $display("FAIL chk_valid: got lat=%0d err=%0d n=%0d want %0d 0 4 hour 92",
                            cap_lat, cap_err, cap_data.size(), LAT);
      end
`else
      capture(1'b0, 3);
      checks++;
      if (cap_lat != LAT || cap_err != 0 || cap_data.size() != 4 || cap_data[2] !== ref_hour(8'h13, 1'b1, 1'b0)) begin
         errors++; $display("FAIL nochk_run: got lat=%0d err=%0d n=%0d want %0d 0 4",
                            cap_lat, cap_err, cap_data.size(), LAT);
      end
`endif
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_sequences();
      test_back_to_back();
      test_reset_mid();
      @(negedge clk);
      test_check();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
